// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM encoding and default widths for the EX-stage ALU.
// Op codes match the ALU_Control decoder outputs bit for bit.
package alu_pkg;

  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefShamtWidth = 5;

  localparam logic [3:0] OpSub     = 4'b0001;
  localparam logic [3:0] OpOr      = 4'b0010;
  localparam logic [3:0] OpAdd     = 4'b0011;
  localparam logic [3:0] OpLui     = 4'b0100;
  localparam logic [3:0] OpSll     = 4'b0101;
  localparam logic [3:0] OpIllegal = 4'b1001;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative left shifter: loads an operand and a count, then shifts one bit per step.
// last_o flags the step whose shifted_o is the final result.
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned SHAMT_WIDTH = DefShamtWidth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   step_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0] amt_i,
  output logic [DATA_WIDTH-1:0]  shifted_o,
  output logic                   last_o
);

  logic [DATA_WIDTH-1:0]  sh_d, sh_q;
  logic [SHAMT_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = data_i;
      cnt_d = amt_i;
    end else if (step_i) begin
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - SHAMT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign shifted_o = sh_q << 1;
  assign last_o    = (cnt_q == SHAMT_WIDTH'(1));

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle ADD/SUB/OR/LUI, iterative SLL, with start/busy/done handshake.
// Result, zero and illegal flags are registered together and held until the next done.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned SHAMT_WIDTH = DefShamtWidth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_data_i,
  input  logic [DATA_WIDTH-1:0]  b_data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  alu_data_o,
  output logic                   zero_o,
  output logic                   illegal_op_o
);

  alu_state_e state_d, state_q;

  logic [DATA_WIDTH-1:0] result_d, result_q;
  logic                  zero_d, zero_q;
  logic                  illegal_d, illegal_q;

  logic [DATA_WIDTH-1:0] op_res;
  logic                  op_illegal;
  logic                  sh_load, sh_step, sh_last;
  logic [DATA_WIDTH-1:0] sh_result;

  // Single-cycle datapath; SLL lands here only for a zero shift amount.
  always_comb begin
    op_res     = '0;
    op_illegal = 1'b0;
    unique case (alu_operation_i)
      OpSub:   op_res = a_data_i - b_data_i;
      OpOr:    op_res = a_data_i | b_data_i;
      OpAdd:   op_res = a_data_i + b_data_i;
      OpLui:   op_res = {b_data_i[15:0], {(DATA_WIDTH - 16){1'b0}}};
      OpSll:   op_res = b_data_i;
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    sh_load   = 1'b0;
    sh_step   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          if (alu_operation_i == OpSll && shamt_i != '0) begin
            sh_load = 1'b1;
            state_d = StShift;
          end else begin
            result_d  = op_res;
            zero_d    = (op_res == '0);
            illegal_d = op_illegal;
            state_d   = StDone;
          end
        end
      end
      StShift: begin
        sh_step = 1'b1;
        if (sh_last) begin
          result_d  = sh_result;
          zero_d    = (sh_result == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  alu_iter_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (sh_load),
    .step_i   (sh_step),
    .data_i   (b_data_i),
    .amt_i    (shamt_i),
    .shifted_o(sh_result),
    .last_o   (sh_last)
  );

  assign busy_o       = (state_q == StShift);
  assign done_o       = (state_q == StDone);
  assign alu_data_o   = result_q;
  assign zero_o       = zero_q;
  assign illegal_op_o = illegal_q;

endmodule
